// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the VGA sync generator to the pixel-graphics layers.
// The generator drives every signal; graphics layers only observe.
interface vga_sync_gen_if #(
    parameter int COORD_W = 10
);
    logic               p_tick;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               video_on;
    logic               hsync;
    logic               vsync;
    logic               frame_start;

    modport master (
        output p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_start
    );

    modport slave (
        input p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing source: pixel-tick divider, position counters and registered
// sync/blanking/frame-start flags that all update on the same clock edge.
module vga_sync_gen #(
    parameter int DVSR     = 2,
    parameter int HD       = 640,
    parameter int HF       = 16,
    parameter int HR       = 96,
    parameter int HB       = 48,
    parameter int VD       = 480,
    parameter int VF       = 10,
    parameter int VR       = 2,
    parameter int VB       = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int COORD_W  = 10
) (
    input  logic           clk,
    input  logic           reset_n,
    vga_sync_gen_if.master o_vga
);
    localparam int H_TOT = HD + HF + HR + HB;
    localparam int V_TOT = VD + VF + VR + VB;
    localparam int TW    = (DVSR > 1) ? $clog2(DVSR) : 1;

    localparam logic [TW-1:0]      TICK_LAST = TW'(DVSR - 1);
    localparam logic [TW-1:0]      TICK_ONE  = TW'(1);
    localparam logic [COORD_W-1:0] ONE       = COORD_W'(1);
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] X_DISP    = COORD_W'(HD);
    localparam logic [COORD_W-1:0] Y_DISP    = COORD_W'(VD);
    localparam logic [COORD_W-1:0] HS_BEG    = COORD_W'(HD + HF);
    localparam logic [COORD_W-1:0] HS_END    = COORD_W'(HD + HF + HR - 1);
    localparam logic [COORD_W-1:0] VS_BEG    = COORD_W'(VD + VF);
    localparam logic [COORD_W-1:0] VS_END    = COORD_W'(VD + VF + VR - 1);

    logic [TW-1:0]      r_tick_cnt;
    logic [TW-1:0]      w_tick_nxt;
    logic               r_p_tick;
    logic [COORD_W-1:0] r_pix_x;
    logic [COORD_W-1:0] r_pix_y;
    logic [COORD_W-1:0] w_x_nxt;
    logic [COORD_W-1:0] w_y_nxt;
    logic               w_x_wrap;
    logic               w_y_wrap;
    logic               w_hs_act;
    logic               w_vs_act;
    logic               w_vid_nxt;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_video_on;
    logic               r_frame_start;

    always_comb begin
        w_tick_nxt = (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TICK_ONE;
        w_x_wrap   = (r_pix_x == X_LAST);
        w_y_wrap   = (r_pix_y == Y_LAST);
        w_x_nxt    = r_pix_x;
        w_y_nxt    = r_pix_y;
        if (r_p_tick) begin
            if (w_x_wrap) begin
                w_x_nxt = '0;
                w_y_nxt = w_y_wrap ? '0 : r_pix_y + ONE;
            end else begin
                w_x_nxt = r_pix_x + ONE;
            end
        end
        // Flags are decoded from the next position so they land with it.
        w_hs_act  = (w_x_nxt >= HS_BEG) && (w_x_nxt <= HS_END);
        w_vs_act  = (w_y_nxt >= VS_BEG) && (w_y_nxt <= VS_END);
        w_vid_nxt = (w_x_nxt < X_DISP) && (w_y_nxt < Y_DISP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt    <= '0;
            r_p_tick      <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_tick_cnt    <= w_tick_nxt;
            r_p_tick      <= (w_tick_nxt == TICK_LAST);
            r_pix_x       <= w_x_nxt;
            r_pix_y       <= w_y_nxt;
            r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            r_video_on    <= w_vid_nxt;
            r_frame_start <= r_p_tick && w_x_wrap && w_y_wrap;
        end
    end

    assign o_vga.p_tick      = r_p_tick;
    assign o_vga.pix_x       = r_pix_x;
    assign o_vga.pix_y       = r_pix_y;
    assign o_vga.video_on    = r_video_on;
    assign o_vga.hsync       = r_hsync;
    assign o_vga.vsync       = r_vsync;
    assign o_vga.frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: full-size line timing, a shrunken
// geometry for frame/wrap/reset timing, and a DVSR=1 positive-sync build.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic rst_def = 1'b0;
    logic rst_sm = 1'b0;
    logic rst_d1 = 1'b0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_sync_gen_if #(.COORD_W(10)) if_def ();
    vga_sync_gen_if #(.COORD_W(5))  if_sm ();
    vga_sync_gen_if #(.COORD_W(10)) if_d1 ();

    vga_sync_gen u_def (
        .clk(clk), .reset_n(rst_def), .o_vga(if_def)
    );

    // Small geometry: H_TOT=16 (hsync x 10..12), V_TOT=10 (vsync y 7..8)
    vga_sync_gen #(
        .DVSR(2), .HD(8), .HF(2), .HR(3), .HB(3),
        .VD(6), .VF(1), .VR(2), .VB(1),
        .SYNC_POL(1'b0), .COORD_W(5)
    ) u_sm (
        .clk(clk), .reset_n(rst_sm), .o_vga(if_sm)
    );

    vga_sync_gen #(
        .DVSR(1), .SYNC_POL(1'b1)
    ) u_d1 (
        .clk(clk), .reset_n(rst_d1), .o_vga(if_d1)
    );

    task automatic test_reset();
        int k;
        @(negedge clk);
        n_vec++;
        if (if_def.pix_x !== 10'd0 || if_def.pix_y !== 10'd0 ||
            if_def.p_tick !== 1'b0 || if_def.hsync !== 1'b1 ||
            if_def.vsync !== 1'b1 || if_def.video_on !== 1'b1 ||
            if_def.frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init: x=%0d y=%0d tick=%b hs=%b vs=%b vo=%b fs=%b, want 0 0 0 1 1 1 0",
                     if_def.pix_x, if_def.pix_y, if_def.p_tick, if_def.hsync,
                     if_def.vsync, if_def.video_on, if_def.frame_start);
        end
        rst_def = 1'b1;
        k = 0;
        while (if_def.pix_x !== 10'd300 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k != 600) begin
            n_err++;
            $display("FAIL reach_x300: clks=%0d, want 600", k);
        end
        #2 rst_def = 1'b0;
        #1;
        n_vec++;
        if (if_def.pix_x !== 10'd0 || if_def.pix_y !== 10'd0 ||
            if_def.p_tick !== 1'b0 || if_def.hsync !== 1'b1 ||
            if_def.vsync !== 1'b1 || if_def.video_on !== 1'b1 ||
            if_def.frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: x=%0d y=%0d tick=%b hs=%b vs=%b vo=%b fs=%b, want 0 0 0 1 1 1 0",
                     if_def.pix_x, if_def.pix_y, if_def.p_tick, if_def.hsync,
                     if_def.vsync, if_def.video_on, if_def.frame_start);
        end
        @(negedge clk);
        rst_def = 1'b1;
        @(negedge clk);
        n_vec++;
        if (if_def.p_tick !== 1'b1 || if_def.pix_x !== 10'd0) begin
            n_err++;
            $display("FAIL first_tick: tick=%b x=%0d, want 1 0",
                     if_def.p_tick, if_def.pix_x);
        end
        @(negedge clk);
        n_vec++;
        if (if_def.p_tick !== 1'b0 || if_def.pix_x !== 10'd1) begin
            n_err++;
            $display("FAIL first_step: tick=%b x=%0d, want 0 1",
                     if_def.p_tick, if_def.pix_x);
        end
    endtask

    task automatic test_line();
        int k;
        int hs_cnt;
        int hs_first;
        int hs_last;
        int vo_cnt;
        int vo_first;
        int tk_cnt;
        int t1;
        int t2;
        logic prev_hs;
        k = 0;
        while (!(if_def.pix_x === 10'd0 && if_def.pix_y === 10'd1) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k >= 4000) begin
            n_err++;
            $display("FAIL line_start_timeout: clks=%0d, want <4000", k);
        end
        hs_cnt = 0; hs_first = -1; hs_last = -1;
        vo_cnt = 0; vo_first = -1; tk_cnt = 0;
        t1 = -1; t2 = -1;
        prev_hs = if_def.hsync;
        for (int i = 0; i < 3200; i++) begin
            if (i < 1600 && if_def.p_tick === 1'b1) begin
                tk_cnt++;
                if (if_def.hsync === 1'b0) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(if_def.pix_x);
                    hs_last = int'(if_def.pix_x);
                end
                if (if_def.video_on === 1'b0) begin
                    vo_cnt++;
                    if (vo_first < 0) vo_first = int'(if_def.pix_x);
                end
            end
            if (prev_hs === 1'b1 && if_def.hsync === 1'b0) begin
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
            end
            prev_hs = if_def.hsync;
            @(negedge clk);
        end
        n_vec++;
        if (tk_cnt != 800) begin
            n_err++;
            $display("FAIL line_ticks: got %0d, want 800", tk_cnt);
        end
        n_vec++;
        if (hs_cnt != 96 || hs_first != 656 || hs_last != 751) begin
            n_err++;
            $display("FAIL hsync_window: cnt=%0d first=%0d last=%0d, want 96 656 751",
                     hs_cnt, hs_first, hs_last);
        end
        n_vec++;
        if (vo_cnt != 160 || vo_first != 640) begin
            n_err++;
            $display("FAIL hblank: cnt=%0d first=%0d, want 160 640", vo_cnt, vo_first);
        end
        n_vec++;
        if (t2 - t1 != 1600 || t1 < 0) begin
            n_err++;
            $display("FAIL hsync_period: got %0d, want 1600", t2 - t1);
        end
        n_vec++;
        if (if_def.pix_x !== 10'd0 || if_def.pix_y !== 10'd3) begin
            n_err++;
            $display("FAIL line_end_pos: x=%0d y=%0d, want 0 3",
                     if_def.pix_x, if_def.pix_y);
        end
    endtask

    task automatic test_dvsr1();
        int px;
        int bad;
        int hs_cnt;
        int hs_first;
        int hs_last;
        int t1;
        int t2;
        logic prev_hs;
        @(negedge clk);
        rst_d1 = 1'b1;
        @(negedge clk);
        n_vec++;
        if (if_d1.p_tick !== 1'b1 || if_d1.pix_x !== 10'd0 || if_d1.hsync !== 1'b0) begin
            n_err++;
            $display("FAIL d1_start: tick=%b x=%0d hs=%b, want 1 0 0",
                     if_d1.p_tick, if_d1.pix_x, if_d1.hsync);
        end
        bad = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        t1 = -1; t2 = -1;
        prev_hs = if_d1.hsync;
        for (int i = 0; i < 1610; i++) begin
            px = int'(if_d1.pix_x);
            if (i < 800 && if_d1.hsync === 1'b1) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = px;
                hs_last = px;
            end
            if (prev_hs === 1'b0 && if_d1.hsync === 1'b1) begin
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
            end
            prev_hs = if_d1.hsync;
            @(negedge clk);
            if (if_d1.p_tick !== 1'b1 || int'(if_d1.pix_x) != (px + 1) % 800)
                bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL d1_increment: bad steps=%0d, want 0", bad);
        end
        n_vec++;
        if (hs_cnt != 96 || hs_first != 656 || hs_last != 751) begin
            n_err++;
            $display("FAIL d1_hsync_window: cnt=%0d first=%0d last=%0d, want 96 656 751",
                     hs_cnt, hs_first, hs_last);
        end
        n_vec++;
        if (t2 - t1 != 800 || t1 < 0) begin
            n_err++;
            $display("FAIL d1_line_period: got %0d, want 800", t2 - t1);
        end
    endtask

    task automatic test_frame();
        int fs_first;
        int fs_cnt;
        int fs_dbl;
        int vs_cnt;
        int hs_cnt;
        int vo_cnt;
        int t1;
        int t2;
        logic prev_vs;
        logic prev_fs;
        @(negedge clk);
        rst_sm = 1'b1;
        fs_first = -1; fs_cnt = 0; fs_dbl = 0;
        vs_cnt = 0; hs_cnt = 0; vo_cnt = 0;
        t1 = -1; t2 = -1;
        prev_vs = if_sm.vsync;
        prev_fs = if_sm.frame_start;
        for (int n = 1; n <= 700; n++) begin
            @(negedge clk);
            if (n <= 320 && if_sm.p_tick === 1'b1) begin
                if (if_sm.vsync === 1'b0) vs_cnt++;
                if (if_sm.hsync === 1'b0) hs_cnt++;
                if (if_sm.video_on === 1'b0) vo_cnt++;
            end
            if (n <= 640 && if_sm.frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = n;
                if (prev_fs === 1'b1) fs_dbl++;
            end
            if (prev_vs === 1'b1 && if_sm.vsync === 1'b0) begin
                if (t1 < 0) t1 = n;
                else if (t2 < 0) t2 = n;
            end
            prev_vs = if_sm.vsync;
            prev_fs = if_sm.frame_start;
        end
        n_vec++;
        if (vs_cnt != 32) begin
            n_err++;
            $display("FAIL vsync_ticks: got %0d, want 32", vs_cnt);
        end
        n_vec++;
        if (hs_cnt != 30) begin
            n_err++;
            $display("FAIL hsync_ticks_frame: got %0d, want 30", hs_cnt);
        end
        n_vec++;
        if (vo_cnt != 112) begin
            n_err++;
            $display("FAIL blank_ticks: got %0d, want 112", vo_cnt);
        end
        n_vec++;
        if (t1 != 224 || t2 - t1 != 320) begin
            n_err++;
            $display("FAIL vsync_period: first=%0d period=%0d, want 224 320", t1, t2 - t1);
        end
        n_vec++;
        if (fs_first != 320 || fs_cnt != 2 || fs_dbl != 0) begin
            n_err++;
            $display("FAIL frame_start_timing: first=%0d cnt=%0d dbl=%0d, want 320 2 0",
                     fs_first, fs_cnt, fs_dbl);
        end
    endtask

    task automatic test_wrap();
        int k;
        k = 0;
        while (!(if_sm.pix_x === 5'd15 && if_sm.pix_y === 5'd9 &&
                 if_sm.p_tick === 1'b1) && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k >= 400) begin
            n_err++;
            $display("FAIL wrap_timeout: clks=%0d, want <400", k);
        end
        @(negedge clk);
        n_vec++;
        if (if_sm.pix_x !== 5'd0 || if_sm.pix_y !== 5'd0 ||
            if_sm.video_on !== 1'b1 || if_sm.frame_start !== 1'b1 ||
            if_sm.hsync !== 1'b1 || if_sm.vsync !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_edge: x=%0d y=%0d vo=%b fs=%b hs=%b vs=%b, want 0 0 1 1 1 1",
                     if_sm.pix_x, if_sm.pix_y, if_sm.video_on, if_sm.frame_start,
                     if_sm.hsync, if_sm.vsync);
        end
        @(negedge clk);
        n_vec++;
        if (if_sm.frame_start !== 1'b0 || if_sm.pix_x !== 5'd0) begin
            n_err++;
            $display("FAIL wrap_pulse_width: fs=%b x=%0d, want 0 0",
                     if_sm.frame_start, if_sm.pix_x);
        end
    endtask

    task automatic test_midreset();
        int k;
        k = 0;
        while (!(if_sm.pix_x === 5'd14 && if_sm.pix_y === 5'd8) && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k >= 400 || if_sm.vsync !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_pre: clks=%0d vs=%b, want <400 0", k, if_sm.vsync);
        end
        #2 rst_sm = 1'b0;
        #1;
        n_vec++;
        if (if_sm.vsync !== 1'b1 || if_sm.hsync !== 1'b1 ||
            if_sm.pix_x !== 5'd0 || if_sm.pix_y !== 5'd0 ||
            if_sm.video_on !== 1'b1 || if_sm.frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_async: vs=%b hs=%b x=%0d y=%0d vo=%b fs=%b, want 1 1 0 0 1 0",
                     if_sm.vsync, if_sm.hsync, if_sm.pix_x, if_sm.pix_y,
                     if_sm.video_on, if_sm.frame_start);
        end
        @(negedge clk);
        rst_sm = 1'b1;
        k = 0;
        while (k < 1000) begin
            @(negedge clk);
            k++;
            if (if_sm.frame_start === 1'b1) break;
        end
        n_vec++;
        if (k != 320) begin
            n_err++;
            $display("FAIL midreset_first_fs: clks=%0d, want 320", k);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_dvsr1();
        test_frame();
        test_wrap();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
